// File: rtl/std_vldrty_array_if.sv
// std_vldrty_array_if: access port, bulk invalidate and dirty-scanner signals of std_vldrty_array.
// The requester drives the master modport, the array owns the slave modport.
interface std_vldrty_array_if #(
    parameter int NumWays = 8,
    parameter int NumSets = 256
);
    localparam int IdxW = $clog2(NumSets);
    localparam int WayW = (NumWays > 1) ? $clog2(NumWays) : 1;

    logic               req_i;
    logic               gnt_o;
    logic               we_i;
    logic [IdxW-1:0]    idx_i;
    logic [NumWays-1:0] wvalid_i;
    logic [NumWays-1:0] wdirty_i;
    logic [NumWays-1:0] be_valid_i;
    logic [NumWays-1:0] be_dirty_i;
    logic [NumWays-1:0] rvalid_o;
    logic [NumWays-1:0] rdirty_o;
    logic               inv_all_i;
    logic               busy_o;
    logic               scan_req_i;
    logic               scan_ack_i;
    logic               scan_valid_o;
    logic [IdxW-1:0]    scan_idx_o;
    logic [WayW-1:0]    scan_way_o;
    logic               scan_done_o;

    modport master (
        output req_i, we_i, idx_i, wvalid_i, wdirty_i, be_valid_i, be_dirty_i,
        output inv_all_i, scan_req_i, scan_ack_i,
        input  gnt_o, rvalid_o, rdirty_o, busy_o,
        input  scan_valid_o, scan_idx_o, scan_way_o, scan_done_o
    );

    modport slave (
        input  req_i, we_i, idx_i, wvalid_i, wdirty_i, be_valid_i, be_dirty_i,
        input  inv_all_i, scan_req_i, scan_ack_i,
        output gnt_o, rvalid_o, rdirty_o, busy_o,
        output scan_valid_o, scan_idx_o, scan_way_o, scan_done_o
    );
endinterface

// File: rtl/std_vldrty_array.sv
// std_vldrty_array: per-set valid/dirty bit array with init/invalidate sweep and dirty-line scanner.
// Define STD_VLDRTY_SCAN_EN to compile in the scanner (SCAN/HOLD states).
module std_vldrty_array #(
    parameter int NumWays = 8,
    parameter int NumSets = 256
) (
    input logic               clk_i,
    input logic               rst_ni,
    std_vldrty_array_if.slave bus
);
    localparam int IdxW = $clog2(NumSets);
    localparam int WayW = (NumWays > 1) ? $clog2(NumWays) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumSets - 1);
    localparam logic [2:0] INIT = 3'd0;
    localparam logic [2:0] IDLE = 3'd1;
    localparam logic [2:0] INV  = 3'd2;
    localparam logic [2:0] SCAN = 3'd3;
    localparam logic [2:0] HOLD = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [IdxW-1:0]    cur_q, cur_d;
    logic [WayW-1:0]    way_q, way_d;
    logic               done_q, done_d;
    logic [NumWays-1:0] rvalid_q, rdirty_q;
    logic [NumWays-1:0] valid_q [NumSets];
    logic [NumWays-1:0] dirty_q [NumSets];
    logic               sweep, live, active, gnt, wr, hold;

    assign sweep  = state_q == INIT || state_q == INV;
    assign live   = state_q == IDLE || state_q == SCAN || state_q == HOLD;
    assign active = rst_ni && live;
    assign gnt    = active && bus.req_i;
    assign wr     = gnt && bus.we_i;
    assign hold   = rst_ni && state_q == HOLD;

    assign bus.gnt_o        = gnt;
    assign bus.busy_o       = !rst_ni || sweep;
    assign bus.rvalid_o     = rvalid_q;
    assign bus.rdirty_o     = rdirty_q;
    assign bus.scan_valid_o = hold;
    assign bus.scan_idx_o   = hold ? cur_q : '0;
    assign bus.scan_way_o   = hold ? way_q : '0;
    assign bus.scan_done_o  = done_q;

`ifdef STD_VLDRTY_SCAN_EN
    logic [NumWays-1:0] hit;
    logic [WayW-1:0]    hit_way;
    logic               ack, port_hit;

    assign ack      = hold && bus.scan_ack_i;
    assign port_hit = wr && bus.idx_i == cur_q;

    always_comb begin
        hit     = valid_q[cur_q] & dirty_q[cur_q];
        hit_way = '0;
        for (int w = NumWays - 1; w >= 0; w--)
            if (hit[w]) hit_way = WayW'(w);
    end
`else
    logic unused_ack;
    assign unused_ack = bus.scan_ack_i;
`endif

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        way_d   = way_q;
        done_d  = 1'b0;
        if (sweep) begin
            // cursor wraps to 0 on the last set, ready for a later scan
            cur_d = cur_q + 1'b1;
            if (cur_q == LastIdx) state_d = IDLE;
        end else if (!live) begin
            state_d = INIT;
            cur_d   = '0;
        end else if (bus.inv_all_i) begin
            state_d = INV;
            cur_d   = '0;
            done_d  = state_q != IDLE;
        end else if (state_q == IDLE) begin
`ifdef STD_VLDRTY_SCAN_EN
            if (bus.scan_req_i) begin
                state_d = SCAN;
                cur_d   = '0;
            end
`else
            done_d = bus.scan_req_i;
`endif
        end
`ifdef STD_VLDRTY_SCAN_EN
        else if (state_q == SCAN) begin
            // a port grant owns the storage this cycle, so the scanner stalls
            if (!gnt) begin
                if (|hit) begin
                    state_d = HOLD;
                    way_d   = hit_way;
                end else if (cur_q == LastIdx) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cur_d = cur_q + 1'b1;
                end
            end
        end else if (ack || port_hit) begin
            state_d = SCAN;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= INIT;
            cur_q    <= '0;
            way_q    <= '0;
            done_q   <= 1'b0;
            rvalid_q <= '0;
            rdirty_q <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            way_q   <= way_d;
            done_q  <= done_d;
            if (gnt) begin
                rvalid_q <= valid_q[bus.idx_i];
                rdirty_q <= dirty_q[bus.idx_i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (sweep) begin
            valid_q[cur_q] <= '0;
            dirty_q[cur_q] <= '0;
        end
        if (wr) begin
            valid_q[bus.idx_i] <= (valid_q[bus.idx_i] & ~bus.be_valid_i) | (bus.wvalid_i & bus.be_valid_i);
            dirty_q[bus.idx_i] <= (dirty_q[bus.idx_i] & ~bus.be_dirty_i) | (bus.wdirty_i & bus.be_dirty_i);
        end
`ifdef STD_VLDRTY_SCAN_EN
        if (ack) dirty_q[cur_q][way_q] <= 1'b0;
`endif
    end
endmodule

// File: doc/std_vldrty_array.md
STD_VLDRTY_ARRAY -- requirements
Module: std_vldrty_array

Interface
REQ-001 SHALL have parameter NumWays, default 8, number of ways, 1..32.
REQ-002 SHALL have parameter NumSets, default 256, number of sets, power of two, >=2; IdxW = $clog2(NumSets).
REQ-003 SHALL have port clk_i  in  1  single clock; one clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  in  1  reset, synchronous and active-low.
REQ-005 SHALL have ports req_i in 1 / gnt_o out 1  access request and same-cycle grant.
REQ-006 SHALL have ports we_i in 1, idx_i in IdxW  write enable and set index.
REQ-007 SHALL have ports wvalid_i, wdirty_i, be_valid_i, be_dirty_i  in  NumWays  write data and per-way bit enables.
REQ-008 SHALL have ports rvalid_o, rdirty_o  out  NumWays  read data.
REQ-009 SHALL have ports inv_all_i in 1 (start bulk invalidate) and busy_o out 1 (init/invalidate sweep running).
REQ-010 SHALL have ports scan_req_i in 1, scan_ack_i in 1, scan_valid_o out 1, scan_idx_o out IdxW, scan_way_o out $clog2(NumWays) (min 1), scan_done_o out 1  dirty-line scanner.

Function
REQ-011 SHALL implement FSM states INIT, IDLE, INV, SCAN, HOLD.
REQ-012 INIT/INV SHALL clear valid and dirty of one set per cycle, idx 0..NumSets-1, then go IDLE; duration exactly NumSets cycles; busy_o=1 and gnt_o=0 throughout.
REQ-013 In IDLE, SCAN, HOLD: gnt_o = req_i (combinational); port has priority over the scanner for storage.
REQ-014 Granted access SHALL present rvalid_o/rdirty_o of idx_i one cycle later, pre-write contents on writes; outputs hold until next grant.
REQ-015 Granted write SHALL update only bits with be_valid_i[w]/be_dirty_i[w] set; visible to a grant in the following cycle.
REQ-016 inv_all_i in IDLE, SCAN or HOLD SHALL enter INV next cycle; an active scan aborts with a one-cycle scan_done_o and scan_valid_o=0; inv_all_i during INIT/INV SHALL be ignored.
REQ-017 scan_req_i in IDLE SHALL enter SCAN with cursor at set 0; ignored in other states.
REQ-018 SCAN SHALL read set at cursor on each cycle without port grant; if any way has valid&dirty, go HOLD with lowest such way on scan_way_o and cursor on scan_idx_o; otherwise advance cursor.
REQ-019 HOLD SHALL drive scan_valid_o=1, outputs stable until scan_ack_i; on ack clear that dirty bit and return SCAN on the same set.
REQ-020 A granted port write to scan_idx_o while in HOLD SHALL drop scan_valid_o next cycle and return SCAN on the same set; port reads do not disturb HOLD.
REQ-021 After the last set (NumSets-1) holds no dirty line, SHALL pulse scan_done_o one cycle and return IDLE; cursor does not wrap.
REQ-022 scan_ack_i without scan_valid_o SHALL be ignored.

Reset
REQ-023 rst_ni=0 at a clock edge SHALL enter INIT, cursor 0, abort any scan/invalidate without scan_done_o.
REQ-024 Reset values: gnt_o=0, busy_o=1, rvalid_o=0, rdirty_o=0, scan_valid_o=0, scan_idx_o=0, scan_way_o=0, scan_done_o=0.

Configuration
REQ-025 Macro STD_VLDRTY_SCAN_EN defined: scanner (REQ-017..022) compiled in.
REQ-026 Macro undefined: no SCAN/HOLD logic; scan_valid_o=0, scan_idx_o=0, scan_way_o=0; scan_req_i in IDLE yields scan_done_o one cycle later; scan_ack_i ignored.

Verification
REQ-027 Reset, NumSets=256: busy_o=1 for 256 cycles, gnt_o=0; then read every set -> rvalid_o=0, rdirty_o=0.
REQ-028 Write idx 5, wvalid=0xFF, wdirty=0x0A, be_valid=0xFF, be_dirty=0x0F; then write idx 5 be_dirty=0x00 wdirty=0xFF; read idx 5 -> rvalid_o=0xFF, rdirty_o=0x0A one cycle after grant.
REQ-029 Dirty ways 3 and 6 in set 7, way 0 in set 200; scan with ack after 2 cycles -> (7,3),(7,6),(200,0), then scan_done_o pulse; rescan -> scan_done_o only, after 256 read cycles.
REQ-030 During HOLD on (7,3), port write idx 7 clearing dirty way 3 -> scan_valid_o drops, next hold (7,6).
REQ-031 inv_all_i mid-scan -> scan_done_o pulse, busy_o=1 for 256 cycles, all reads 0; macro undefined: scan_req_i -> scan_done_o next cycle, scan_valid_o never 1.
